apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/data_types_pkg.sv | 14 +
 rtl/apb_timeout_counter.sv | 33 +++
 rtl/apb_master.sv | 128 ++++++++++++
 tb/tb_apb_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_types_pkg.sv
// Shared types and width defaults for the APB requester block.
package data_types_pkg;

    localparam int WIDTH          = 32;
    localparam int ADDR_WIDTH_RAM = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter for the APB ACCESS phase; flags the cycle in which the
// wait budget would be exhausted so the FSM can leave on that same edge.
module apb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_C  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Saturating count of ACCESS cycles spent without pready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != LIMIT_C)) begin
            count_r <= count_r + 1'b1;
        end
    end

    // This increment is the one that reaches the budget.
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_r == LAST_C);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns the result on a valid/ready response channel.
module apb_master
    import data_types_pkg::*;
#(
    parameter int DATA_WIDTH     = WIDTH,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_RAM,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    apb_master_state_t     state_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  cnt_clear_s;
    logic                  cnt_enable_s;
    logic                  cnt_expired_s;

    assign cnt_clear_s  = (state_r == SETUP);
    assign cnt_enable_s = (state_r == ACCESS) && !pready;

    apb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .expired(cnt_expired_s)
    );

    // Transfer sequencing; every APB and response output is a flop of this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            paddr_r     <= '0;
            pwdata_r    <= '0;
            rsp_rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_r  <= cmd_addr;
                        pwdata_r <= cmd_wdata;
                        pwrite_r <= cmd_write;
                        psel_r   <= 1'b1;
                        state_r  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
                end
                ACCESS: begin
                    // A completer answering on the last allowed cycle still wins.
                    if (pready) begin
                        rsp_rdata_r <= pwrite_r ? '0 : prdata;
                        rsp_err_r   <= pslverr;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (cnt_expired_s) begin
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;
    assign pwrite    = pwrite_r;
    assign psel      = psel_r;
    assign penable   = penable_r;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed and random transfer tables,
// back-to-back throughput and reset-abort sequences.
module tb_apb_master;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 16;
    localparam int NDIR = 6;
    localparam int NRND = 20;
    localparam logic [31:0] XKEY = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_acc;
    } vec_t;

    vec_t tbl[NDIR+NRND];

    apb_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Outcome of a transfer from the completer's behaviour: answer on ACCESS
    // cycle waits+1 unless the wait budget runs out first.
    function automatic vec_t model(input vec_t v);
        bit timeout;
        timeout     = (v.waits >= TMO);
        v.exp_acc   = timeout ? TMO : v.waits + 1;
        v.exp_err   = timeout || v.slverr;
        v.exp_rdata = (timeout || v.wr) ? 32'h0 : v.prdata;
        return v;
    endfunction

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int waits, input logic [31:0] prd, input logic serr,
                                input int hold, input logic e_err, input logic [31:0] e_rd,
                                input int e_acc);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.prdata = prd;
        v.slverr = serr; v.hold = hold; v.exp_err = e_err; v.exp_rdata = e_rd; v.exp_acc = e_acc;
        return v;
    endfunction

    task automatic run_xfer(input vec_t v, input string tag);
        int n;
        int acc;
        int setup;
        int rsp_cyc;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".cmd_ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        acc = 0; setup = 0; rsp_cyc = 0;
        for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            check({tag, ".cmd_ready_busy"}, 64'(cmd_ready), 64'(0));
            check({tag, ".penable_wo_psel"}, 64'(penable && !psel), 64'(0));
            if (psel) begin
                check({tag, ".paddr"}, 64'(paddr), 64'(v.addr));
                check({tag, ".pwrite"}, 64'(pwrite), 64'(v.wr));
                if (v.wr) check({tag, ".pwdata"}, 64'(pwdata), 64'(v.wdata));
            end
            if (psel && !penable) setup++;
            if (psel && penable) acc++;
            pready  = psel && penable && (acc == v.waits + 1);
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'($urandom);
            if (rsp_valid) rsp_cyc = c;
        end
        pready = 1'b0;
        check({tag, ".rsp_seen"}, 64'(rsp_cyc != 0), 64'(1));
        if (rsp_cyc == 0) return;
        check({tag, ".setup_cycles"}, 64'(setup), 64'(1));
        check({tag, ".access_cycles"}, 64'(acc), 64'(v.exp_acc));
        check({tag, ".rsp_latency"}, 64'(rsp_cyc), 64'(2 + v.exp_acc));
        check({tag, ".rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, ".resp_psel"}, 64'({psel, penable}), 64'(0));
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(rsp_valid), 64'(1));
            check({tag, ".hold_err"}, 64'(rsp_err), 64'(v.exp_err));
            check({tag, ".hold_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
            check({tag, ".hold_cmd_ready"}, 64'(cmd_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".rsp_done"}, 64'(rsp_valid), 64'(0));
        check({tag, ".back_idle"}, 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        int acc_t[3];
        int nacc;
        int got;
        bit pend;
        vec_t v;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.psel_penable", 64'({psel, penable}), 64'(0));
        check("rst.pwrite_rspv_err", 64'({pwrite, rsp_valid, rsp_err}), 64'(0));
        check("rst.paddr", 64'(paddr), 64'(0));
        check("rst.pwdata", 64'(pwdata), 64'(0));
        check("rst.rsp_rdata", 64'(rsp_rdata), 64'(0));
        rst = 1'b0;
        check("rst.cmd_ready_first", 64'(cmd_ready), 64'(1));

        // Directed table with hand-derived expectations, then random rows via the model
        tbl[0] = mk(1'b1, 32'h10, 32'hA5A5, 0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1);
        tbl[1] = mk(1'b0, 32'h20, 32'h0, 3, 32'h1234, 1'b0, 0, 1'b0, 32'h1234, 4);
        tbl[2] = mk(1'b0, 32'h30, 32'h0, 16, 32'hFFFF, 1'b0, 1, 1'b1, 32'h0, 16);
        tbl[3] = mk(1'b0, 32'h40, 32'h0, 15, 32'hBEEF, 1'b0, 0, 1'b0, 32'hBEEF, 16);
        tbl[4] = mk(1'b0, 32'h50, 32'h0, 0, 32'hDEAD, 1'b1, 5, 1'b1, 32'hDEAD, 1);
        tbl[5] = mk(1'b1, 32'h60, 32'h77, 2, 32'h9999, 1'b1, 0, 1'b1, 32'h0, 3);
        for (int i = NDIR; i < NDIR + NRND; i++) begin
            v.wr = 1'($urandom); v.addr = $urandom; v.wdata = $urandom;
            v.waits = int'($urandom_range(0, 20)); v.prdata = $urandom;
            v.slverr = 1'($urandom); v.hold = int'($urandom_range(0, 2));
            tbl[i] = model(v);
        end
        for (int i = 0; i < NDIR + NRND; i++) begin
            run_xfer(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back reads with cmd_valid held and rsp_ready high
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h200;
        nacc = 0; got = 0; pend = 1'b0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (pend) begin
                pend = 1'b0;
                if (nacc < 3) cmd_addr = 32'h200 + 32'(4 * nacc);
                else cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready && nacc < 3) begin
                acc_t[nacc] = c;
                nacc++;
                pend = 1'b1;
            end
            pready = psel && penable;
            prdata = pready ? (paddr ^ XKEY) : $urandom;
            pslverr = 1'b0;
            if (rsp_valid) begin
                check($sformatf("b2b.rdata%0d", got), 64'(rsp_rdata),
                      64'((32'h200 + 32'(4 * got)) ^ XKEY));
                check($sformatf("b2b.err%0d", got), 64'(rsp_err), 64'(0));
                got++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
        check("b2b.responses", 64'(got), 64'(3));
        check("b2b.accepts", 64'(nacc), 64'(3));
        if (nacc == 3) begin
            check("b2b.gap01", 64'(acc_t[1] - acc_t[0]), 64'(4));
            check("b2b.gap12", 64'(acc_t[2] - acc_t[1]), 64'(4));
        end
        repeat (2) @(negedge clk);

        // Reset pulsed in the middle of ACCESS
        check("rstmid.ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid.in_access", 64'({psel, penable}), 64'(3));
        rst = 1'b1;
        #1;
        check("rstmid.psel_drop", 64'({psel, penable}), 64'(0));
        check("rstmid.no_rsp", 64'(rsp_valid), 64'(0));
        check("rstmid.paddr_clr", 64'(paddr), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.ready_first", 64'(cmd_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstmid.quiet", 64'({rsp_valid, psel}), 64'(0));
        end
        run_xfer(mk(1'b0, 32'h400, 32'h0, 1, 32'hCAFE, 1'b0, 0, 1'b0, 32'hCAFE, 2), "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
